// File: rtl/rib_mem_slave.sv
// RIB bus memory slave: word-organised data RAM answering each accepted request
// with a single-cycle acknowledge after WAIT_CYCLES wait states.
module rib_mem_slave #(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rib_req_i,
   input  logic        rib_we_i,
   input  logic [31:0] rib_addr_i,
   input  logic [31:0] rib_wr_data_i,
   input  logic [3:0]  rib_wr_sel_i,
   output logic        rib_ack_o,
   output logic [31:0] rib_rd_data_o,
   output logic        rib_err_o,
   output logic        rib_busy_o
);

   localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
   localparam int unsigned TagLsb = ADDR_WIDTH + 2;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  sel_q, sel_d;
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic        rd_zero_q, rd_zero_d;
   logic [31:0] ram_dout_q;
   logic [31:0] mem [Depth];

   logic                  go_resp;
   logic                  acc_we;
   logic [31:0]           acc_addr;
   logic [31:0]           acc_wdata;
   logic [3:0]            acc_sel;
   logic                  acc_hit;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic                  unused_addr_bits;

   // With no wait states the access happens on the accept edge, so use the live bus.
   always_comb begin
      acc_we    = (state_q == StIdle) ? rib_we_i      : we_q;
      acc_addr  = (state_q == StIdle) ? rib_addr_i    : addr_q;
      acc_wdata = (state_q == StIdle) ? rib_wr_data_i : wdata_q;
      acc_sel   = (state_q == StIdle) ? rib_wr_sel_i  : sel_q;
      acc_hit   = (acc_addr[31:TagLsb] == BASE_ADDR[31:TagLsb]);
      acc_idx   = acc_addr[TagLsb-1:2];
   end

   assign unused_addr_bits = ^acc_addr[1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      sel_d     = sel_q;
      go_resp   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rib_req_i) begin
               we_d    = rib_we_i;
               addr_d  = rib_addr_i;
               wdata_d = rib_wr_data_i;
               sel_d   = rib_wr_sel_i;
               if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
                  go_resp = 1'b1;
               end else begin
                  cnt_d   = 4'(WAIT_CYCLES - 1);
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      ack_d     = go_resp;
      busy_d    = (state_d != StIdle);
      err_d     = go_resp ? !acc_hit : err_q;
      rd_zero_d = rd_zero_q;
      if (go_resp) begin
         if (!acc_hit)     rd_zero_d = 1'b1;
         else if (!acc_we) rd_zero_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         we_q      <= 1'b0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         sel_q     <= 4'd0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_zero_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         sel_q     <= sel_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         rd_zero_q <= rd_zero_d;
      end
   end

   // RAM and its output register are never reset; rd_zero_q masks the output after
   // reset and on misses, and ram_dout_q only moves on read hits so it holds otherwise.
   always_ff @(posedge clk) begin
      if (rst_n && go_resp && acc_hit) begin
         if (acc_we) begin
            for (int b = 0; b < 4; b++) begin
               if (acc_sel[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end else begin
            ram_dout_q <= mem[acc_idx];
         end
      end
   end

   assign rib_ack_o     = ack_q;
   assign rib_busy_o    = busy_q;
   assign rib_err_o     = err_q;
   assign rib_rd_data_o = rd_zero_q ? 32'd0 : ram_dout_q;

endmodule

// File: tb/tb_rib_mem_slave.sv
// Scoreboard bench for rib_mem_slave: three instances (WAIT_CYCLES 0, 1, 3) driven in
// turn; expected acks are queued at issue time and checked by a negedge monitor.
module tb_rib_mem_slave;

   typedef struct {
      int          d;
      int          cyc;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req, we, ack, err, busy;
   logic [31:0] addr [3];
   logic [31:0] wdata [3];
   logic [3:0]  sel [3];
   logic [31:0] rdata [3];

   int   wc [3] = '{0, 1, 3};
   int   cyc    = 0;
   int   checks = 0;
   int   fails  = 0;
   exp_t sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rib_mem_slave #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .rib_req_i(req[0]), .rib_we_i(we[0]),
      .rib_addr_i(addr[0]), .rib_wr_data_i(wdata[0]), .rib_wr_sel_i(sel[0]),
      .rib_ack_o(ack[0]), .rib_rd_data_o(rdata[0]), .rib_err_o(err[0]),
      .rib_busy_o(busy[0])
   );
   rib_mem_slave #(.WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .rib_req_i(req[1]), .rib_we_i(we[1]),
      .rib_addr_i(addr[1]), .rib_wr_data_i(wdata[1]), .rib_wr_sel_i(sel[1]),
      .rib_ack_o(ack[1]), .rib_rd_data_o(rdata[1]), .rib_err_o(err[1]),
      .rib_busy_o(busy[1])
   );
   rib_mem_slave #(.WAIT_CYCLES(3)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .rib_req_i(req[2]), .rib_we_i(we[2]),
      .rib_addr_i(addr[2]), .rib_wr_data_i(wdata[2]), .rib_wr_sel_i(sel[2]),
      .rib_ack_o(ack[2]), .rib_rd_data_o(rdata[2]), .rib_err_o(err[2]),
      .rib_busy_o(busy[2])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called just after a posedge; returns just after the edge on which the DUT is idle
   // again, so a following issue() is a back-to-back request.
   task automatic issue(input int d, input logic we_v, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] s,
                        input logic [31:0] exp_rd, input logic exp_err, input bit scram);
      exp_t e;
      req[d]   = 1'b1;
      we[d]    = we_v;
      addr[d]  = a;
      wdata[d] = dat;
      sel[d]   = s;
      e.d   = d;
      e.cyc = cyc + 1 + wc[d];
      e.rd  = exp_rd;
      e.err = exp_err;
      sb.push_back(e);
      @(posedge clk); #1;
      if (scram) begin
         we[d]    = 1'b0;
         addr[d]  = 32'h2000_0000;
         wdata[d] = 32'hFFFF_FFFF;
         sel[d]   = 4'h0;
      end
      repeat (wc[d] + 1) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int d);
      req[d] = 1'b0;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (ack[d] === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL spurious_ack: instance %0d acked at cycle %0d, expected no ack",
                        d, cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("ack_instance", d, e.d);
               check("ack_cycle", cyc, e.cyc);
               check("rd_data", rdata[d], e.rd);
               check("err", {31'd0, err[d]}, {31'd0, e.err});
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0; sel[i] = 4'd0;
      end
      // Request held during reset must not be acted upon.
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h1000_0010;
      wdata[1] = 32'hDEAD_BEEF; sel[1] = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ack", {31'd0, ack[1]}, 32'd0);
      check("reset_busy", {31'd0, busy[1]}, 32'd0);
      check("reset_err", {31'd0, err[1]}, 32'd0);
      check("reset_rd_data", rdata[1], 32'd0);
      rst_n = 1'b1;

      // WAIT_CYCLES = 1: write/read, byte enables, sel=0, decode miss
      issue(1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0, 1'b0);
      idle(1);
      issue(1, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
      idle(1);
      issue(1, 1'b1, 32'h1000_0010, 32'h0000_5500, 4'b0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
      issue(1, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 32'hDEAD_55EF, 1'b0, 1'b0);
      issue(1, 1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'b0000, 32'hDEAD_55EF, 1'b0, 1'b0);
      issue(1, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 32'hDEAD_55EF, 1'b0, 1'b0);
      issue(1, 1'b0, 32'h2000_0000, 32'h0, 4'hF, 32'h0000_0000, 1'b1, 1'b0);
      issue(1, 1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b1, 1'b0);
      issue(1, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 32'hDEAD_55EF, 1'b0, 1'b0);
      issue(1, 1'b0, 32'h1000_0013, 32'h0, 4'hF, 32'hDEAD_55EF, 1'b0, 1'b0);
      idle(1);

      // WAIT_CYCLES = 0: back-to-back, inputs scrambled during RESP
      issue(0, 1'b1, 32'h1000_0000, 32'h1111_1111, 4'hF, 32'h0000_0000, 1'b0, 1'b1);
      issue(0, 1'b1, 32'h1000_0004, 32'h2222_2222, 4'hF, 32'h0000_0000, 1'b0, 1'b1);
      issue(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 32'h1111_1111, 1'b0, 1'b1);
      issue(0, 1'b0, 32'h1000_0004, 32'h0, 4'hF, 32'h2222_2222, 1'b0, 1'b1);
      issue(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 32'h1111_1111, 1'b0, 1'b1);
      idle(0);

      // WAIT_CYCLES = 3: back-to-back, inputs scrambled during WAIT
      issue(2, 1'b1, 32'h1000_0020, 32'hAAAA_5555, 4'hF, 32'h0000_0000, 1'b0, 1'b0);
      issue(2, 1'b1, 32'h1000_0024, 32'h0BAD_CAFE, 4'hF, 32'h0000_0000, 1'b0, 1'b1);
      issue(2, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 32'hAAAA_5555, 1'b0, 1'b1);
      issue(2, 1'b0, 32'h1000_0024, 32'h0, 4'hF, 32'h0BAD_CAFE, 1'b0, 1'b1);
      idle(2);

      // Reset pulse in the second WAIT cycle aborts the write and produces no ack.
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h1000_0020;
      wdata[2] = 32'h1234_5678; sel[2] = 4'hF;
      @(posedge clk); #1;
      req[2] = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      check("busy_after_reset", {31'd0, busy[2]}, 32'd0);
      repeat (6) @(posedge clk);
      #1;
      check("busy_idle_after_abort", {31'd0, busy[2]}, 32'd0);
      issue(2, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 32'hAAAA_5555, 1'b0, 1'b0);
      idle(2);

      repeat (4) @(posedge clk);
      #1;
      check("pending_acks", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
